// File: rtl/mips_load_store_unit_if.sv
// Avalon-style data-bus bundle between the load/store unit (master) and memory (slave).
interface mips_load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_load_store_unit.sv
// Memory-access stage of the multicycle MIPS CPU.
// Issues one bus transaction per request, builds byte enables and replicated
// store lanes, aligns and extends load data, and rejects misaligned or
// illegal accesses without touching the bus.
// Optional: define MIPS_LSU_UNALIGNED_EN to support LWL/LWR (size codes 010/110);
// without it those codes are illegal and finish with addr_error.
module mips_load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              is_store_i,
    input  logic [2:0]        size_code_i,
    input  logic [ADDR_W-1:0] eff_addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] rt_old_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              addr_error_o,
    output logic [DATA_W-1:0] load_result_o,
    mips_load_store_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                is_store_q;
    logic [2:0]          size_q;
    logic [1:0]          lane_q;
    logic                err_q;
    logic [ADDR_W-1:0]   address_q;
    logic [3:0]          be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   load_result_q;

    logic                accept;
    logic                req_misaligned;
    logic                req_illegal;
    logic                req_err;
    logic [3:0]          req_be;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_fmt;
    logic                load_done;

`ifdef MIPS_LSU_UNALIGNED_EN
    localparam bit UNALIGNED_EN = 1'b1;
    logic [DATA_W-1:0] rt_old_q;
    logic [4:0]        lwl_shift;
    logic [4:0]        lwr_shift;
    logic [DATA_W-1:0] lwl_mask;
    assign lwl_shift = {~lane_q, 3'b000};
    assign lwr_shift = {lane_q, 3'b000};
    assign lwl_mask  = (32'h1 << lwl_shift) - 32'h1;

    // Capture the old rt value on accept so LWL/LWR can merge into it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rt_old_q <= '0;
        end else if (accept) begin
            rt_old_q <= rt_old_i;
        end
    end
`else
    localparam bit UNALIGNED_EN = 1'b0;
    logic unused_rt_old;
    assign unused_rt_old = ^rt_old_i;
`endif

    assign accept    = (state_q == IDLE) && start_i;
    assign req_err   = req_misaligned || req_illegal;
    assign load_done = (state_q == ACCESS) && !bus.waitrequest && !is_store_q;

    // Classify the incoming request: alignment, legality, lanes and store data.
    always_comb begin
        req_misaligned = 1'b0;
        req_illegal    = 1'b0;
        req_be         = 4'b1111;
        req_wdata      = store_data_i;
        if (is_store_i) begin
            case (size_code_i)
                3'b000:  ;
                3'b001:  req_misaligned = eff_addr_i[0];
                3'b011:  req_misaligned = |eff_addr_i[1:0];
                default: req_illegal = 1'b1;
            endcase
        end else begin
            case (size_code_i)
                3'b000, 3'b100: ;
                3'b001, 3'b101: req_misaligned = eff_addr_i[0];
                3'b011:         req_misaligned = |eff_addr_i[1:0];
                3'b010, 3'b110: req_illegal = !UNALIGNED_EN;
                default:        req_illegal = 1'b1;
            endcase
        end
        case (size_code_i)
            3'b000, 3'b100: req_be = 4'b0001 << eff_addr_i[1:0];
            3'b001, 3'b101: req_be = eff_addr_i[1] ? 4'b1100 : 4'b0011;
            default:        req_be = 4'b1111;
        endcase
        case (size_code_i)
            3'b000:  req_wdata = {4{store_data_i[7:0]}};
            3'b001:  req_wdata = {2{store_data_i[15:0]}};
            default: req_wdata = store_data_i;
        endcase
    end

    // Align the returned word to the addressed lane and extend/merge it.
    always_comb begin
        shifted  = bus.readdata >> {lane_q, 3'b000};
        load_fmt = bus.readdata;
        case (size_q)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_fmt = {24'h0, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_fmt = {16'h0, shifted[15:0]};
`ifdef MIPS_LSU_UNALIGNED_EN
            3'b010:  load_fmt = (bus.readdata << lwl_shift) | (rt_old_q & lwl_mask);
            3'b110:  load_fmt = (bus.readdata >> lwr_shift) |
                                (rt_old_q & ~(32'hFFFF_FFFF >> lwr_shift));
`endif
            default: load_fmt = bus.readdata;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: rejected requests skip the bus and go straight to the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = req_err ? RESP : ACCESS;
            ACCESS:  if (!bus.waitrequest) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches and load result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_store_q    <= 1'b0;
            size_q        <= 3'b000;
            lane_q        <= 2'b00;
            err_q         <= 1'b0;
            address_q     <= '0;
            be_q          <= 4'b0000;
            wdata_q       <= '0;
            load_result_q <= '0;
        end else begin
            if (accept) begin
                is_store_q <= is_store_i;
                size_q     <= size_code_i;
                lane_q     <= eff_addr_i[1:0];
                err_q      <= req_err;
                if (!req_err) begin
                    address_q <= {eff_addr_i[ADDR_W-1:2], 2'b00};
                    be_q      <= req_be;
                    wdata_q   <= req_wdata;
                end
            end
            if (load_done) begin
                load_result_q <= load_fmt;
            end
        end
    end

    // Outputs decoded from the current state and the latched request.
    always_comb begin
        busy_o         = (state_q != IDLE);
        done_o         = (state_q == RESP);
        addr_error_o   = (state_q == RESP) && err_q;
        load_result_o  = load_result_q;
        bus.read       = (state_q == ACCESS) && !is_store_q;
        bus.write      = (state_q == ACCESS) && is_store_q;
        bus.address    = address_q;
        bus.byteenable = be_q;
        bus.writedata  = wdata_q;
    end

endmodule
